boss_controller: RTL
====================

# boss_controller

Sequences the boss stage: runs the boss through entry, fight, dying and dead phases and schedules its attacks. Each attack produces a one-cycle `shoot_pulse` for the boss missile spawner. The same cycle also drives `switch_direction_pulse` and a pseudo-random `random_axis` into the boss motion block. The controller counts hits against a health budget and reports death to the stage/score logic. Everything is paced by `startOfFrame`.

## Interface
Parameters:
- `MAX_HEALTH`, default 8: hits needed to kill the boss; legal range 1..255.
- `SHOT_INTERVAL`, default 45: frames between shots in FIGHT; legal range 1..255.
- `ENTRY_FRAMES`, default 60: frames spent in ENTER; legal range 1..255.
- `DEATH_FRAMES`, default 30: frames spent in DYING; legal range 1..255.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: asynchronous reset, active-low.
- `startOfFrame`, in, 1: one-cycle pulse at the start of each frame.
- `stage_start`, in, 1: pulse that starts or restarts the boss.
- `boss_hit`, in, 1: one-cycle pulse per player missile hit on the boss.
- `shoot_pulse`, out, 1: one-cycle request to fire a boss missile.
- `switch_direction_pulse`, out, 1: one-cycle pulse, identical to `shoot_pulse`.
- `random_axis`, out, 1: axis select; 1 selects Y, 0 selects X. Holds its value between shots.
- `boss_visible`, out, 1: high in ENTER, FIGHT and DYING.
- `boss_dying`, out, 1: high in DYING (drives the explosion sprite).
- `boss_dead_pulse`, out, 1: one cycle on the DYING→DEAD transition.
- `health`, out, 8: remaining health.

## Operation
- All outputs are registered.
- Reset values: every output 0, `health` 0, state IDLE, all counters 0, LFSR = `LFSR_SEED`.
- State machine, where "frame" means a cycle with `startOfFrame`=1:
  - IDLE: on `stage_start` go to ENTER; set `health`=`MAX_HEALTH` and frame counter=0.
  - ENTER: count frames. On the frame where the counter equals `ENTRY_FRAMES`-1, go to FIGHT and clear both counters.
  - FIGHT: the shot counter increments each frame. On the frame where it equals the active interval minus 1, it clears and the shot fires. Firing means that in the next cycle `shoot_pulse`=`switch_direction_pulse`=1 and `random_axis`=LFSR bit 0 as sampled at the firing frame.
  - DYING: count frames. On the frame where the counter equals `DEATH_FRAMES`-1, go to DEAD and pulse `boss_dead_pulse` in the next cycle.
  - DEAD: on `stage_start`, go to ENTER exactly as from IDLE.
- Hits:
  - `boss_hit` counts only in FIGHT.
  - With `health`>1, a hit decrements `health`.
  - With `health`=1, a hit sets `health`=0 and moves to DYING with the frame counter at 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting left with the feedback bit entering bit 0. It advances on every frame in every state.
- Boundary cases:
  - `stage_start` in ENTER, FIGHT or DYING is ignored.
  - A hit in ENTER or DYING is ignored.
  - A killing hit in the same cycle as a firing frame suppresses the shot.
  - A non-killing hit coincident with a firing frame: both take effect.
  - `boss_hit` and `startOfFrame` in the same cycle are both processed.
  - Interval 1 fires on every frame.
  - Asserting reset mid-fight returns everything to reset values immediately.

## Timing
- Pulse outputs are exactly one cycle long and appear 1 cycle after the qualifying `startOfFrame`.
- `health` and state update 1 cycle after the `boss_hit` edge.
- `boss_visible` and `boss_dying` follow the state register, so they change 1 cycle after the transition condition.
- There is no handshake: the spawner must accept `shoot_pulse` unconditionally.

## Configuration
- Macro: `BOSS_RAGE_EN`.
- Defined: in FIGHT, while `health` ≤ `MAX_HEALTH`/2 (integer division), the active interval is `SHOT_INTERVAL`/2, with a minimum of 1.
  - At the moment the interval switches, the shot counter is compared with ≥ rather than ==, so an already-exceeded count fires on the next frame.
- Undefined: the active interval is always `SHOT_INTERVAL`.

## Structure
- Package `boss_pkg`:
  - `boss_state_t` enum: IDLE, ENTER, FIGHT, DYING, DEAD.
  - LFSR width and tap constants.
  - `HEALTH_W`=8.
- Sub-module `boss_lfsr` with ports `clk`, `resetN`, `advance`, `seed` parameter and `value[7:0]`. It is instantiated once.

## Test plan
Parameters for all scenarios: `MAX_HEALTH`=4, `SHOT_INTERVAL`=6, `ENTRY_FRAMES`=3, `DEATH_FRAMES`=2.
- Reset, then frames with no `stage_start` → all outputs stay 0 and state stays IDLE; `health`=0.
- `stage_start`, then 3 frames → `boss_visible`=1 from the next cycle, FIGHT after frame 3, and no shots during ENTER.
- In FIGHT, 12 frames with no hits → exactly 2 `shoot_pulse`s, one cycle after frames 6 and 12. `switch_direction_pulse` is identical to `shoot_pulse`, and `random_axis` equals the LFSR golden-model bit 0.
- 4 hits in FIGHT, the last coincident with a firing frame → `health` goes 3,2,1,0, no shot is fired, `boss_dying`=1, and after 2 frames `boss_dead_pulse`=1 for one cycle with `boss_visible`=0.
- With `BOSS_RAGE_EN`: 2 hits bring `health` to 2 → shots come every 3 frames. Without the macro → shots stay every 6 frames.
- Reset asserted mid-FIGHT; `stage_start` and `boss_hit` during ENTER and DYING → immediate return to reset values on reset, and the ignored inputs cause no `health` or state change.

Source files
------------

// File: rtl/boss_pkg.sv
// Shared types and constants for the boss stage controller.
package boss_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      FIGHT,
      DYING,
      DEAD
   } boss_state_t;

   localparam int HEALTH_W = 8;
   localparam int LFSR_W   = 8;

   // Fibonacci taps 8,6,5,4 expressed as a mask on bits [7:0]
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/boss_lfsr.sv
// Free-running 8-bit pseudo-random source for the boss attack axis.
module boss_lfsr
   import boss_pkg::*;
#(
   parameter logic [LFSR_W-1:0] seed = 8'hA5
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (advance) value_d = lfsr_next(value_q);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) value_q <= seed;
      else         value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/boss_controller.sv
// Boss stage sequencer: entry, fight with scheduled shots, dying and dead phases.
// Optional macro BOSS_RAGE_EN halves the shot interval once health drops to half.
//
// state | meaning
// IDLE  | no boss, waiting for stage_start
// ENTER | boss slides in, counting ENTRY_FRAMES
// FIGHT | boss shoots every active interval and takes hits
// DYING | explosion, counting DEATH_FRAMES
// DEAD  | boss gone, stage_start restarts it
module boss_controller
   import boss_pkg::*;
#(
   parameter int                MAX_HEALTH    = 8,
   parameter int                SHOT_INTERVAL = 45,
   parameter int                ENTRY_FRAMES  = 60,
   parameter int                DEATH_FRAMES  = 30,
   parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                startOfFrame,
   input  logic                stage_start,
   input  logic                boss_hit,
   output logic                shoot_pulse,
   output logic                switch_direction_pulse,
   output logic                random_axis,
   output logic                boss_visible,
   output logic                boss_dying,
   output logic                boss_dead_pulse,
   output logic [HEALTH_W-1:0] health
);

   localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
   localparam logic [7:0]          ENTRY_LAST  = 8'(ENTRY_FRAMES - 1);
   localparam logic [7:0]          DEATH_LAST  = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0]          SHOT_LAST   = 8'(SHOT_INTERVAL - 1);
`ifdef BOSS_RAGE_EN
   localparam int                  RAGE_INTERVAL = (SHOT_INTERVAL / 2 < 1) ? 1 : SHOT_INTERVAL / 2;
   localparam logic [7:0]          RAGE_LAST     = 8'(RAGE_INTERVAL - 1);
   localparam logic [HEALTH_W-1:0] RAGE_HEALTH   = HEALTH_W'(MAX_HEALTH / 2);
`endif

   boss_state_t         state_q, state_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
   logic [7:0]          shot_cnt_q, shot_cnt_d;
   logic [HEALTH_W-1:0] health_q, health_d;
   logic                shoot_q, shoot_d;
   logic                axis_q, axis_d;
   logic                visible_q, visible_d;
   logic                dying_q, dying_d;
   logic                dead_pulse_q, dead_pulse_d;
   logic                fire_frame;
   logic                kill;
   logic [LFSR_W-1:0]   lfsr_value;

   boss_lfsr #(.seed(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .resetN  (resetN),
      .advance (startOfFrame),
      .value   (lfsr_value)
   );

   // >= lets a count already past the shortened interval fire on the next frame
`ifdef BOSS_RAGE_EN
   assign fire_frame = (health_q <= RAGE_HEALTH) ? (shot_cnt_q >= RAGE_LAST)
                                                 : (shot_cnt_q >= SHOT_LAST);
`else
   assign fire_frame = (shot_cnt_q == SHOT_LAST);
`endif

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      shot_cnt_d   = shot_cnt_q;
      health_d     = health_q;
      shoot_d      = 1'b0;
      axis_d       = axis_q;
      dead_pulse_d = 1'b0;
      kill         = 1'b0;
      case (state_q)
         IDLE, DEAD: begin
            if (stage_start) begin
               state_d     = ENTER;
               health_d    = HEALTH_INIT;
               frame_cnt_d = 8'd0;
               shot_cnt_d  = 8'd0;
            end
         end
         ENTER: begin
            if (startOfFrame) begin
               if (frame_cnt_q == ENTRY_LAST) begin
                  state_d     = FIGHT;
                  frame_cnt_d = 8'd0;
                  shot_cnt_d  = 8'd0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
         FIGHT: begin
            if (boss_hit) begin
               if (health_q > 8'd1) begin
                  health_d = health_q - 8'd1;
               end else begin
                  health_d    = 8'd0;
                  state_d     = DYING;
                  frame_cnt_d = 8'd0;
                  kill        = 1'b1;
               end
            end
            // a killing hit pre-empts any shot on the same frame
            if (startOfFrame && !kill) begin
               if (fire_frame) begin
                  shot_cnt_d = 8'd0;
                  shoot_d    = 1'b1;
                  axis_d     = lfsr_value[0];
               end else begin
                  shot_cnt_d = shot_cnt_q + 8'd1;
               end
            end
         end
         DYING: begin
            if (startOfFrame) begin
               if (frame_cnt_q == DEATH_LAST) begin
                  state_d      = DEAD;
                  frame_cnt_d  = 8'd0;
                  dead_pulse_d = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      visible_d = (state_d == ENTER) || (state_d == FIGHT) || (state_d == DYING);
      dying_d   = (state_d == DYING);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         frame_cnt_q  <= 8'd0;
         shot_cnt_q   <= 8'd0;
         health_q     <= '0;
         shoot_q      <= 1'b0;
         axis_q       <= 1'b0;
         visible_q    <= 1'b0;
         dying_q      <= 1'b0;
         dead_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         shot_cnt_q   <= shot_cnt_d;
         health_q     <= health_d;
         shoot_q      <= shoot_d;
         axis_q       <= axis_d;
         visible_q    <= visible_d;
         dying_q      <= dying_d;
         dead_pulse_q <= dead_pulse_d;
      end
   end

   assign shoot_pulse            = shoot_q;
   assign switch_direction_pulse = shoot_q;
   assign random_axis            = axis_q;
   assign boss_visible           = visible_q;
   assign boss_dying             = dying_q;
   assign boss_dead_pulse        = dead_pulse_q;
   assign health                 = health_q;

endmodule
